// File: rtl/flasher_pkg.sv
// Shared types and thresholds for the LED flasher controller.
// The downstream LED counter decodes the same behaviour codes.
package flasher_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ON1  = 3'd1,
        OFF1 = 3'd2,
        ON2  = 3'd3,
        OFF2 = 3'd4,
        ON3  = 3'd5,
        OFF3 = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        DECREASE = 2'b00,
        INCREASE = 2'b01,
        PASS     = 2'b11
    } bhv_t;

    localparam logic [CNT_W-1:0] TH_ZERO = 5'd0;
    localparam logic [CNT_W-1:0] TH_LOW  = 5'd5;
    localparam logic [CNT_W-1:0] TH_ONE  = 5'd6;
    localparam logic [CNT_W-1:0] TH_TWO  = 5'd11;
    localparam logic [CNT_W-1:0] TH_FULL = 5'd16;

    function automatic bhv_t bhv_of(input state_t s);
        bhv_t b;
        b = PASS;
        unique case (1'b1)
            (s == ON1) || (s == ON2) || (s == ON3):    b = INCREASE;
            (s == OFF1) || (s == OFF2) || (s == OFF3): b = DECREASE;
            default:                                   b = PASS;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/flasher_if.sv
// Bundle between the flasher FSM and the LED counter side.
// slave = FSM, master = counter / environment.
interface flasher_if;
    import flasher_pkg::*;

    logic             flick;
    logic [CNT_W-1:0] count;
    logic [1:0]       led_bhv;
    logic [2:0]       state;

    modport master (
        output flick,
        output count,
        input  led_bhv,
        input  state
    );

    modport slave (
        input  flick,
        input  count,
        output led_bhv,
        output state
    );

endinterface

// File: rtl/flasher_sync.sv
// Two-flop synchronizer bringing the asynchronous flick request
// into the div_clk domain.
module flasher_sync (
    input  logic div_clk,
    input  logic rst,
    input  logic flick,
    output logic flick_s
);

    logic meta;

    // Two-stage capture; both stages cleared by async reset.
    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            meta    <= 1'b0;
            flick_s <= 1'b0;
        end else begin
            meta    <= flick;
            flick_s <= meta;
        end
    end

endmodule

// File: rtl/flasher_fsm.sv
// Flasher sequencer: three rise/fall waves to 6, 11 and 16 LEDs.
// Build option FLASHER_KICKBACK_EN enables flick kickback in ON2/ON3.
module flasher_fsm
    import flasher_pkg::*;
#(
    parameter int LED_NUMBER   = 16,
    parameter int LED_NUMBER_W = $clog2(LED_NUMBER)
) (
    input logic       div_clk,
    input logic       rst,
    flasher_if.slave  bus
);

    localparam logic [LED_NUMBER_W:0] CNT_MAX =
        (LED_NUMBER_W+1)'(LED_NUMBER);

    logic [LED_NUMBER_W:0] cnt;
    logic                  flick_s;
    logic                  kick;
    state_t                state_q;
    state_t                state_d;

    assign cnt = bus.count;

    flasher_sync u_sync (
        .div_clk (div_clk),
        .rst     (rst),
        .flick   (bus.flick),
        .flick_s (flick_s)
    );

`ifdef FLASHER_KICKBACK_EN
    assign kick = flick_s;
`else
    assign kick = 1'b0;
`endif

    // State register, cleared to IDLE asynchronously.
    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: advance when count hits the phase target.
    always_comb begin
        state_d = state_q;
        if (cnt > CNT_MAX) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (flick_s) state_d = ON1;
                ON1:  if (cnt == TH_ONE) state_d = OFF1;
                OFF1: if (cnt == TH_ZERO) state_d = ON2;
                ON2: begin
                    if (kick && (cnt == TH_ONE || cnt == TH_TWO))
                        state_d = OFF1;
                    else if (cnt == TH_TWO)
                        state_d = OFF2;
                end
                OFF2: if (cnt == TH_LOW) state_d = ON3;
                ON3: begin
                    if (kick && (cnt == TH_TWO || cnt == TH_FULL))
                        state_d = OFF2;
                    else if (cnt == TH_FULL)
                        state_d = OFF3;
                end
                OFF3: if (cnt == TH_ZERO) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Command the counter from next_state so it stops exactly on target.
    always_comb begin
        bus.state   = state_q;
        bus.led_bhv = rst ? PASS : bhv_of(state_d);
    end

endmodule

// File: tb/tb_flasher_fsm.sv
// Scoreboard bench for flasher_fsm with an in-bench LED counter.
// Reference model walks a phase table of targets, not the RTL FSM.
module tb_flasher_fsm;
    import flasher_pkg::*;

    bit   div_clk = 1'b1;
    logic rst;
    logic glitch_en;
    logic [4:0] glitch_val;

    flasher_if bus ();

    flasher_fsm dut (
        .div_clk (div_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 div_clk = ~div_clk;

    // Downstream LED counter, closing the loop.
    always @(posedge div_clk or posedge rst) begin
        if (rst) bus.count <= 5'd0;
        else if (glitch_en) bus.count <= glitch_val;
        else begin
            case (bus.led_bhv)
                2'b01:   bus.count <= bus.count + 5'd1;
                2'b00:   bus.count <= bus.count - 5'd1;
                default: bus.count <= bus.count;
            endcase
        end
    end

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] bhv;
        logic [4:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e_exp;
    exp_t e_got;
    int   vectors = 0;
    int   misses  = 0;
    event chk_ev;

    // Model: phase k (0 idle, 1..6 waves), lamp count, synchronizer.
    int         mk;
    logic [4:0] mc;
    logic       ms1, ms2;
    int         tgt [7] = '{0, 6, 0, 11, 5, 16, 0};

    function automatic int nxt(input int k, input logic [4:0] c,
                               input logic fs);
        if (c > 5'd16) return 0;
        if (k == 0) return fs ? 1 : 0;
`ifdef FLASHER_KICKBACK_EN
        if (fs && k == 3 && (c == 5'd6 || c == 5'd11)) return 2;
        if (fs && k == 5 && (c == 5'd11 || c == 5'd16)) return 4;
`endif
        if (int'(c) == tgt[k]) return (k + 1) % 7;
        return k;
    endfunction

    function automatic logic [1:0] bhv(input int k);
        if (k == 0) return 2'b11;
        return ((k % 2) == 1) ? 2'b01 : 2'b00;
    endfunction

    function automatic exp_t expect_now();
        exp_t x;
        x.st  = 3'(mk);
        x.bhv = bhv(nxt(mk, mc, ms2));
        x.cnt = mc;
        return x;
    endfunction

    task automatic mreset();
        mk  = 0;
        mc  = 5'd0;
        ms1 = 1'b0;
        ms2 = 1'b0;
    endtask

    task automatic step(input logic f, input logic r = 1'b0,
                        input logic ge = 1'b0,
                        input logic [4:0] gv = 5'd0);
        int nk;
        @(negedge div_clk);
        rst        = r;
        bus.flick  = f;
        glitch_en  = ge;
        glitch_val = gv;
        if (r) begin
            mreset();
        end else begin
            nk = nxt(mk, mc, ms2);
            if (ge) mc = gv;
            else if (nk == 0) mc = mc;
            else if ((nk % 2) == 1) mc = mc + 5'd1;
            else mc = mc - 5'd1;
            ms2 = ms1;
            ms1 = f;
            mk  = nk;
        end
        sb.push_back(expect_now());
    endtask

    task automatic async_reset();
        @(negedge div_clk);
        #2;
        rst       = 1'b1;
        bus.flick = 1'b0;
        mreset();
        sb.push_back(expect_now());
        ->chk_ev;
        sb.push_back(expect_now());
    endtask

    task automatic run_until(input int k, input int c, input logic f,
                             input int budget);
        int n;
        n = 0;
        while (!(mk == k && int'(mc) == c) && n < budget) begin
            step(f);
            n++;
        end
        if (!(mk == k && int'(mc) == c)) begin
            misses++;
            $display("FAIL wait_phase: got phase=%0d count=%0d, want phase=%0d count=%0d within %0d cycles",
                     mk, mc, k, c, budget);
        end
    endtask

    task automatic run_while(input int k, input logic f,
                             input int budget);
        int n;
        n = 0;
        while (mk == k && n < budget) begin
            step(f);
            n++;
        end
        if (mk == k) begin
            misses++;
            $display("FAIL leave_phase: got phase=%0d still, want exit within %0d cycles",
                     mk, budget);
        end
    endtask

    // Monitor: compare DUT outputs against queued expectations.
    initial begin
        forever begin
            @(posedge div_clk or chk_ev);
            #1;
            vectors++;
            if (sb.size() == 0) begin
                misses++;
                $display("FAIL cyc@%0t: got an output, want a queued expectation", $time);
            end else begin
                e_exp = sb.pop_front();
                e_got = {bus.state, bus.led_bhv, bus.count};
                if (e_got !== e_exp) begin
                    misses++;
                    $display("FAIL cyc@%0t: got state=%0d bhv=%b count=%0d, want state=%0d bhv=%b count=%0d",
                             $time, e_got.st, e_got.bhv, e_got.cnt,
                             e_exp.st, e_exp.bhv, e_exp.cnt);
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        bus.flick  = 1'b0;
        glitch_en  = 1'b0;
        glitch_val = 5'd0;
        mreset();

        repeat (3) step(1'b0, 1'b1);
        repeat (20) step(1'b0);

        repeat (3) step(1'b1);
        repeat (70) step(1'b0);

        repeat (3) step(1'b1);
        run_until(3, 8, 1'b0, 100);
        run_while(3, 1'b1, 50);
        repeat (90) step(1'b0);

        repeat (3) step(1'b1);
        run_until(5, 13, 1'b0, 200);
        run_while(5, 1'b1, 50);
        repeat (80) step(1'b0);

        repeat (3) step(1'b1);
        run_until(5, 8, 1'b0, 200);
        async_reset();
        repeat (2) step(1'b0, 1'b1);
        repeat (10) step(1'b0);

        repeat (3) step(1'b1);
        run_until(3, 4, 1'b0, 200);
        step(1'b0, 1'b0, 1'b1, 5'd20);
        repeat (3) step(1'b0);
        repeat (3) step(1'b1);
        step(1'b0, 1'b0, 1'b1, 5'd0);
        repeat (5) step(1'b0);

        repeat (600) step($urandom_range(0, 15) == 0);

        @(posedge div_clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, misses);
        $finish;
    end

endmodule
